// File: rtl/board_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : board_renderer_if
// Brief    : Pixel-stream bundle between the VGA timing side and the board
//            renderer: timing strobes, board snapshot inputs, RGB pixel out.
// Revision : 1.0 - initial release
// ============================================================================
interface board_renderer_if #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int COLOR_W = 3
);
    localparam int CUR_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic                     visible_i;
    logic                     frame_start_i;
    logic [2*ROWS*COLS-1:0]   board_i;
    logic [CUR_W-1:0]         cursor_col_i;
    logic                     cursor_valid_i;
    logic [ROWS*COLS-1:0]     win_mask_i;
    logic                     pix_valid_o;
    logic [COLOR_W-1:0]       red_o;
    logic [COLOR_W-1:0]       green_o;
    logic [COLOR_W-1:0]       blue_o;

    modport master (
        output visible_i, frame_start_i, board_i, cursor_col_i, cursor_valid_i, win_mask_i,
        input  pix_valid_o, red_o, green_o, blue_o
    );

    modport slave (
        input  visible_i, frame_start_i, board_i, cursor_col_i, cursor_valid_i, win_mask_i,
        output pix_valid_o, red_o, green_o, blue_o
    );
endinterface
`default_nettype wire

// File: rtl/board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : board_renderer
// Brief    : Two-stage pipelined disc-drop board renderer with column cursor;
//            define WIN_BLINK_EN to enable the blinking win-cell highlight.
// Revision : 1.0 - initial release
// ============================================================================
module board_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int ROWS         = 6,
    parameter int COLS         = 7,
    parameter int CELL_W       = 80,
    parameter int CELL_H       = 80,
    parameter int ORIGIN_X     = 40,
    parameter int ORIGIN_Y     = 0,
    parameter int RADIUS       = 30,
    parameter int COLOR_W      = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  wire              clk,
    input  wire              rst_n,
    board_renderer_if.slave  bus
);

    localparam int XW       = $clog2(H_ACTIVE);
    localparam int YW       = $clog2(V_ACTIVE);
    localparam int LXW      = $clog2(CELL_W);
    localparam int LYW      = $clog2(CELL_H);
    localparam int CW       = $clog2(COLS) + 1;
    localparam int RW       = $clog2(ROWS) + 1;
    localparam int NCELL    = ROWS * COLS;
    localparam int IW       = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int CUR_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CELL_MAX = (CELL_W > CELL_H) ? CELL_W : CELL_H;
    localparam int DW       = $clog2(CELL_MAX) + 1;
    localparam int D2W      = 2 * DW + 1;
    localparam int X_END    = ORIGIN_X + COLS * CELL_W;
    localparam int Y_END    = ORIGIN_Y + ROWS * CELL_H;

    localparam logic [XW-1:0]      X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]      Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [LXW-1:0]     LX_LAST = LXW'(CELL_W - 1);
    localparam logic [LYW-1:0]     LY_LAST = LYW'(CELL_H - 1);
    localparam logic [COLOR_W-1:0] C_MAX   = {COLOR_W{1'b1}};

    // ------------------------------------------------------------------------
    // Raster and cell counters
    // ------------------------------------------------------------------------
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;
    logic [LXW-1:0] lx_q;
    logic [LYW-1:0] ly_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic           active_q;
    logic           w_count;

    // active_q stays low after reset and after the last pixel, until re-sync
    assign w_count = bus.visible_i && !bus.frame_start_i && active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            lx_q     <= '0;
            ly_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            active_q <= 1'b0;
        end else if (bus.frame_start_i) begin
            x_q      <= '0;
            y_q      <= '0;
            lx_q     <= '0;
            ly_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            active_q <= 1'b1;
        end else if (w_count) begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
                active_q <= 1'b0;
            end else if (x_q == X_LAST) begin
                x_q   <= '0;
                lx_q  <= '0;
                col_q <= '0;
                y_q   <= y_q + 1'b1;
                if (int'(y_q) >= ORIGIN_Y) begin
                    if (ly_q == LY_LAST) begin
                        ly_q  <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        ly_q  <= ly_q + 1'b1;
                    end
                end
            end else begin
                x_q <= x_q + 1'b1;
                if (int'(x_q) >= ORIGIN_X) begin
                    if (lx_q == LX_LAST) begin
                        lx_q  <= '0;
                        col_q <= col_q + 1'b1;
                    end else begin
                        lx_q  <= lx_q + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-frame snapshot of the board state
    // ------------------------------------------------------------------------
    logic [2*NCELL-1:0] board_q;
    logic [CUR_W-1:0]   cursor_q;
    logic               cursor_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q        <= '0;
            cursor_q       <= '0;
            cursor_valid_q <= 1'b0;
        end else if (bus.frame_start_i) begin
            board_q        <= bus.board_i;
            cursor_q       <= bus.cursor_col_i;
            cursor_valid_q <= bus.cursor_valid_i;
        end
    end

`ifdef WIN_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [NCELL-1:0] win_q;
    logic [BW-1:0]    blink_cnt_q;
    logic             blink_q;
    logic             blink_snap_q;

    // The frame uses the phase in force before this frame_start's update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q        <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            blink_snap_q <= 1'b0;
        end else if (bus.frame_start_i) begin
            win_q        <= bus.win_mask_i;
            blink_snap_q <= blink_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end
`else
    logic w_unused_win;
    assign w_unused_win = ^bus.win_mask_i;
`endif

    // ------------------------------------------------------------------------
    // Stage 1: inside flag, cell index, signed offsets from the cell centre
    // ------------------------------------------------------------------------
    logic                 w_inside;
    logic [IW-1:0]        w_cell;
    logic [DW-1:0]        w_dx;
    logic [DW-1:0]        w_dy;

    logic                 s1_valid_q;
    logic                 s1_draw_q;
    logic                 s1_inside_q;
    logic [IW-1:0]        s1_cell_q;
    logic [CW-1:0]        s1_col_q;
    logic signed [DW-1:0] s1_dx_q;
    logic signed [DW-1:0] s1_dy_q;

    assign w_inside = (int'(x_q) >= ORIGIN_X) && (int'(x_q) < X_END) &&
                      (int'(y_q) >= ORIGIN_Y) && (int'(y_q) < Y_END);
    assign w_cell   = w_inside ? IW'(int'(row_q) * COLS + int'(col_q)) : '0;
    assign w_dx     = DW'(int'(lx_q) - CELL_W / 2);
    assign w_dy     = DW'(int'(ly_q) - CELL_H / 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_draw_q   <= 1'b0;
            s1_inside_q <= 1'b0;
            s1_cell_q   <= '0;
            s1_col_q    <= '0;
            s1_dx_q     <= '0;
            s1_dy_q     <= '0;
        end else begin
            s1_valid_q  <= bus.visible_i && !bus.frame_start_i;
            s1_draw_q   <= w_count;
            s1_inside_q <= w_inside;
            s1_cell_q   <= w_cell;
            s1_col_q    <= col_q;
            s1_dx_q     <= w_dx;
            s1_dy_q     <= w_dy;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: disc test and colour selection
    // ------------------------------------------------------------------------
    logic signed [D2W-1:0] w_dx_ext;
    logic signed [D2W-1:0] w_dy_ext;
    logic signed [D2W-1:0] w_dist2;
    logic                  w_disc;
    logic [1:0]            w_code;
    logic                  w_cursor;
    logic                  w_win;
    logic [COLOR_W-1:0]    red_d;
    logic [COLOR_W-1:0]    green_d;
    logic [COLOR_W-1:0]    blue_d;

    assign w_dx_ext = D2W'(s1_dx_q);
    assign w_dy_ext = D2W'(s1_dy_q);
    assign w_dist2  = w_dx_ext * w_dx_ext + w_dy_ext * w_dy_ext;
    assign w_disc   = int'(w_dist2) < RADIUS * RADIUS;
    assign w_code   = board_q[{s1_cell_q, 1'b0} +: 2];
    assign w_cursor = cursor_valid_q && (int'(cursor_q) < COLS) &&
                      (int'(cursor_q) == int'(s1_col_q));
`ifdef WIN_BLINK_EN
    assign w_win    = win_q[s1_cell_q] && blink_snap_q;
`else
    assign w_win    = 1'b0;
`endif

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (s1_draw_q && s1_inside_q) begin
            if (w_disc) begin
                if (w_win) begin
                    red_d   = C_MAX;
                    green_d = C_MAX;
                    blue_d  = C_MAX;
                end else begin
                    case (w_code)
                        2'b01: red_d = C_MAX;
                        2'b10: begin
                            red_d   = C_MAX;
                            green_d = C_MAX;
                        end
                        2'b11: begin
                            red_d   = C_MAX;
                            green_d = C_MAX;
                            blue_d  = C_MAX;
                        end
                        default: ;
                    endcase
                end
            end else if (w_cursor) begin
                green_d = C_MAX;
                blue_d  = C_MAX;
            end else begin
                blue_d  = C_MAX;
            end
        end
    end

    logic               pix_valid_q;
    logic [COLOR_W-1:0] red_q;
    logic [COLOR_W-1:0] green_q;
    logic [COLOR_W-1:0] blue_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_q <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            pix_valid_q <= s1_valid_q;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

    assign bus.pix_valid_o = pix_valid_q;
    assign bus.red_o       = red_q;
    assign bus.green_o     = green_q;
    assign bus.blue_o      = blue_q;

endmodule
`default_nettype wire

// File: tb/tb_board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_renderer
// Brief    : Directed self-checking bench for board_renderer (640x480 instance
//            plus a tiny 16x8 instance for end-of-frame freeze behaviour).
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_renderer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    board_renderer_if #(.ROWS(6), .COLS(7), .COLOR_W(3)) bus ();
    board_renderer_if #(.ROWS(2), .COLS(4), .COLOR_W(3)) sbus ();

    board_renderer u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    board_renderer #(
        .H_ACTIVE(16), .V_ACTIVE(8), .ROWS(2), .COLS(4), .CELL_W(4), .CELL_H(4),
        .ORIGIN_X(0), .ORIGIN_Y(0), .RADIUS(100), .COLOR_W(3), .BLINK_FRAMES(30)
    ) u_small (.clk(clk), .rst_n(rst_n), .bus(sbus));

    localparam logic [8:0] BLACK = 9'o000;
    localparam logic [8:0] RED   = 9'o700;
    localparam logic [8:0] YEL   = 9'o770;
    localparam logic [8:0] WHITE = 9'o777;
    localparam logic [8:0] BLUE  = 9'o007;
    localparam logic [8:0] CYAN  = 9'o077;

    logic [8:0] rgb;
    logic [8:0] srgb;
    assign rgb  = {bus.red_o, bus.green_o, bus.blue_o};
    assign srgb = {sbus.red_o, sbus.green_o, sbus.blue_o};

    int n_checks = 0;
    int n_pass   = 0;
    int pos      = 0;

    task automatic set_cell(input int r, input int c, input logic [1:0] code);
        bus.board_i[(r*7+c)*2 +: 2] = code;
    endtask

    task automatic frame();
        bus.frame_start_i = 1'b1;
        bus.visible_i     = 1'b0;
        @(negedge clk);
        bus.frame_start_i = 1'b0;
        pos = 0;
    endtask

    // Streams visible pixels up to and including (tx,ty); returns with that pixel on the outputs
    task automatic render(input int tx, input int ty);
        int n;
        n = ty*640 + tx - pos + 1;
        for (int i = 0; i < n; i++) begin
            bus.visible_i = 1'b1;
            @(negedge clk);
        end
        bus.visible_i = 1'b0;
        pos += n;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.visible_i = 0; bus.frame_start_i = 0; bus.board_i = '0;
        bus.cursor_col_i = '0; bus.cursor_valid_i = 0; bus.win_mask_i = '0;
        sbus.visible_i = 0; sbus.frame_start_i = 0; sbus.board_i = '0;
        sbus.cursor_col_i = '0; sbus.cursor_valid_i = 0; sbus.win_mask_i = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.pix_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.pix_valid_o); else n_pass++;
        n_checks++; if (rgb !== BLACK) $display("FAIL reset_rgb: got %o want %o", rgb, BLACK); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        set_cell(0, 0, 2'b01);
        frame();
        for (int i = 0; i < 4; i++) begin
            bus.visible_i = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (bus.pix_valid_o !== 1'b1) $display("FAIL pre_reset_valid: got %0b want 1", bus.pix_valid_o); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.pix_valid_o !== 1'b0) $display("FAIL midreset_valid: got %0b want 0", bus.pix_valid_o); else n_pass++;
        n_checks++; if (rgb !== BLACK) $display("FAIL midreset_rgb: got %o want %o", rgb, BLACK); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rgb !== BLACK) $display("FAIL unsynced_black: got %o want %o", rgb, BLACK); else n_pass++;
        bus.visible_i = 1'b0;
        frame();
        render(0, 0);
        n_checks++; if (bus.pix_valid_o !== 1'b1) $display("FAIL px00_valid: got %0b want 1", bus.pix_valid_o); else n_pass++;
        n_checks++; if (rgb !== BLACK) $display("FAIL px00_rgb: got %o want %o", rgb, BLACK); else n_pass++;
    endtask

    task automatic test_pixels();
        bus.board_i = '0;
        set_cell(0, 0, 2'b01);
        set_cell(0, 1, 2'b11);
        set_cell(0, 2, 2'b00);
        bus.cursor_col_i = 3'd3; bus.cursor_valid_i = 1'b1; bus.win_mask_i = '0;
        frame();
        render(41, 1);
        n_checks++; if (rgb !== BLUE) $display("FAIL blue_41_1: got %o want %o", rgb, BLUE); else n_pass++;
        render(281, 1);
        n_checks++; if (rgb !== CYAN) $display("FAIL cursor_281_1: got %o want %o", rgb, CYAN); else n_pass++;
        render(20, 10);
        n_checks++; if (rgb !== BLACK) $display("FAIL outside_20_10: got %o want %o", rgb, BLACK); else n_pass++;
        render(80, 40);
        n_checks++; if (rgb !== RED) $display("FAIL red_80_40: got %o want %o", rgb, RED); else n_pass++;
        n_checks++; if (bus.pix_valid_o !== 1'b1) $display("FAIL valid_80_40: got %0b want 1", bus.pix_valid_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.pix_valid_o !== 1'b0) $display("FAIL idle_valid: got %0b want 0", bus.pix_valid_o); else n_pass++;
        render(160, 40);
        n_checks++; if (rgb !== WHITE) $display("FAIL white_160_40: got %o want %o", rgb, WHITE); else n_pass++;
        render(240, 40);
        n_checks++; if (rgb !== BLACK) $display("FAIL empty_240_40: got %o want %o", rgb, BLACK); else n_pass++;
        bus.cursor_col_i = 3'd7;
        frame();
        render(281, 1);
        n_checks++; if (rgb !== BLUE) $display("FAIL cursor7_281_1: got %o want %o", rgb, BLUE); else n_pass++;
    endtask

    task automatic test_snapshot();
        bus.board_i = '0;
        set_cell(0, 0, 2'b01);
        bus.cursor_valid_i = 1'b0;
        frame();
        render(80, 11);
        n_checks++; if (rgb !== RED) $display("FAIL snap_before: got %o want %o", rgb, RED); else n_pass++;
        set_cell(0, 0, 2'b10);
        render(81, 11);
        n_checks++; if (rgb !== RED) $display("FAIL snap_hold: got %o want %o", rgb, RED); else n_pass++;
        frame();
        render(80, 11);
        n_checks++; if (rgb !== YEL) $display("FAIL snap_next: got %o want %o", rgb, YEL); else n_pass++;
    endtask

    task automatic test_win_blink();
        logic [8:0] exp;
        bus.board_i = '0;
        set_cell(0, 0, 2'b10);
        bus.win_mask_i = '0;
        bus.win_mask_i[0] = 1'b1;
        bus.cursor_valid_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 60; f++) begin
            frame();
            if (f == 0 || f == 29 || f == 30 || f == 59) begin
`ifdef WIN_BLINK_EN
                exp = (f >= 30) ? WHITE : YEL;
`else
                exp = YEL;
`endif
                render(80, 11);
                n_checks++;
                if (rgb !== exp) $display("FAIL win_frame%0d: got %o want %o", f, rgb, exp); else n_pass++;
            end
        end
    endtask

    task automatic test_freeze();
        int k;
        sbus.board_i = 16'h5555;
        sbus.frame_start_i = 1'b1;
        @(negedge clk);
        sbus.frame_start_i = 1'b0;
        for (int i = 0; i < 140; i++) begin
            sbus.visible_i = (i < 138);
            @(negedge clk);
            k = i - 1;
            if (k == 0 || k == 127) begin
                n_checks++;
                if (srgb !== RED) $display("FAIL small_px%0d: got %o want %o", k, srgb, RED); else n_pass++;
            end else if (k >= 128 && k < 138) begin
                n_checks++;
                if (srgb !== BLACK) $display("FAIL frozen_px%0d: got %o want %o", k, srgb, BLACK); else n_pass++;
            end
        end
        sbus.visible_i = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_pixels();
        test_snapshot();
        test_win_blink();
        test_freeze();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
